fifo1c_rd_stream: RTL and testbench
===================================

FIFO1C_RD_STREAM -- requirements
Module: fifo1c_rd_stream

Interface
REQ-001 SHALL have parameter DW, default 144, data width of FIFO entry and output word.
REQ-002 SHALL have parameter RD_LAT, default 1, cycles from fifo_rdreq high to valid fifo_q; legal values 1 and 2 only.
REQ-003 SHALL fix skid buffer depth at 4 entries, internal, not a parameter.
REQ-004 SHALL have a single clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 fifo_empty  input  1  upstream FIFO empty flag, valid every cycle including after back-to-back pops.
REQ-008 fifo_rdreq  output  1  pop request to upstream FIFO.
REQ-009 fifo_q  input  DW  upstream read data, valid RD_LAT cycles after fifo_rdreq.
REQ-010 out_valid  output  1  out_data holds a valid word.
REQ-011 out_data  output  DW  head-of-skid word.
REQ-012 out_ready  input  1  downstream accepts word when high with out_valid.
REQ-013 flush  input  1  synchronous discard of buffered and in-flight words.
REQ-014 occ  output  3  skid occupancy, 0..4.
REQ-015 word_cnt  output  32  words delivered (out_valid & out_ready) since reset.
REQ-016 flush_drop  output  1  one-cycle pulse when flush discarded at least one buffered or in-flight word.

Function
REQ-017 fifo_rdreq SHALL be combinational: !fifo_empty & !flush & (occ + inflight) < 4, where inflight = count of outstanding reads.
REQ-018 Credit check SHALL count the word being popped this cycle as free, i.e. use (occ + inflight - pop) < 4, pop = out_valid & out_ready.
REQ-019 Outstanding reads SHALL be tracked by an RD_LAT-bit shift register; bit 0 loads fifo_rdreq, top bit marks fifo_q valid this cycle.
REQ-020 On a valid fifo_q cycle the word SHALL be written at the skid tail; occ never exceeds 4 (overrun is a design error, flagged by assertion).
REQ-021 out_valid SHALL equal (occ != 0); out_data SHALL be the oldest stored word, registered (no combinational fifo_q to out_data path).
REQ-022 Simultaneous push and pop SHALL leave occ unchanged and preserve order; push into empty skid with out_ready high SHALL appear on out_data the next cycle, not same cycle.
REQ-023 Throughput SHALL be one word per cycle sustained when fifo_empty low and out_ready high, for both RD_LAT values.
REQ-024 out_valid SHALL hold and out_data SHALL remain stable while out_ready low.
REQ-025 Skid read/write pointers SHALL be 2 bits and wrap modulo 4.
REQ-026 flush high SHALL, next edge: set occ to 0, clear all in-flight bits, ignore fifo_q returning from those reads, suppress fifo_rdreq in the flush cycle; a pop in the flush cycle SHALL still count in word_cnt.
REQ-027 flush_drop SHALL pulse the cycle after flush when (occ - pop) + inflight > 0 at the flush cycle.
REQ-028 word_cnt SHALL increment by 1 per pop and wrap from 0xFFFFFFFF to 0.

Reset
REQ-029 On rst_n low, asynchronously: fifo_rdreq effective inputs held inactive via cleared state, out_valid 0, occ 0, in-flight bits 0, pointers 0, word_cnt 0, flush_drop 0; out_data reset to 0.
REQ-030 Reset mid-transfer SHALL discard all buffered and in-flight words; first fifo_rdreq after release no earlier than the first edge with rst_n high.

Verification
REQ-031 RD_LAT=1, FIFO holds 10 words, out_ready=1 -> 10 consecutive out_valid cycles, data in order, word_cnt=10, fifo_rdreq low once fifo_empty.
REQ-032 RD_LAT=2, out_ready=0, FIFO holds 8 -> exactly 4 pops issued, occ=4, out_data=word0 stable; out_ready=1 -> remaining 8 delivered, no loss/duplicate.
REQ-033 out_ready toggling 1/0 each cycle, FIFO holds 20, both RD_LAT -> order preserved, occ <= 4 always, word_cnt=20.
REQ-034 flush with occ=3 and 1 in flight -> next cycle occ=0, out_valid 0, flush_drop pulse, late fifo_q ignored, next delivered word = next FIFO entry.
REQ-035 rst_n low with occ=2 mid-stream -> all outputs at REQ-029 values immediately, no out_valid until new fifo_q returns.
REQ-036 word_cnt preset via force to 0xFFFFFFFE, deliver 3 words -> word_cnt reads 0x00000001.

Source files
------------

// File: rtl/fifo1c_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo1c_rd_stream
//
// Turns a fixed-latency upstream FIFO read port into a valid/ready stream.
// A 4-entry skid buffer absorbs the words that are still in flight when the
// downstream stalls. Pops are issued only when a skid slot is guaranteed for
// the returning word, so the skid can never overrun.
//
// Parameters
//   DW      data width of a FIFO entry / output word
//   RD_LAT  cycles from fifo_rdreq to valid fifo_q (1 or 2)
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   fifo_empty  upstream FIFO empty flag
//   fifo_rdreq  pop request to upstream FIFO (combinational)
//   fifo_q      upstream read data, valid RD_LAT cycles after fifo_rdreq
//   out_valid   out_data holds a valid word
//   out_data    oldest word in the skid (registered)
//   out_ready   downstream accepts the word when high with out_valid
//   flush       synchronous discard of buffered and in-flight words
//   occ         skid occupancy, 0..4
//   word_cnt    words delivered since reset, wraps at 2^32
//   flush_drop  one-cycle pulse after a flush that discarded something
// -----------------------------------------------------------------------------
module fifo1c_rd_stream #(
  parameter int DW     = 144,
  parameter int RD_LAT = 1      // only 1 and 2 are supported
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fifo_empty,
  output logic          fifo_rdreq,
  input  logic [DW-1:0] fifo_q,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  input  logic          flush,
  output logic [2:0]    occ,
  output logic [31:0]   word_cnt,
  output logic          flush_drop
);

  localparam int DEPTH = 4;

  logic [DW-1:0]     mem [DEPTH];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [1:0]        rd_ptr_nxt;
  logic [2:0]        occ_nxt;
  logic [RD_LAT-1:0] inflight_sr;   // bit i set: read issued i+1 cycles ago
  logic [1:0]        inflight_cnt;
  logic [3:0]        credit_used;
  logic [DW-1:0]     head_nxt;
  logic              run;           // low until the first edge out of reset
  logic              pop;
  logic              push;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_cnt = inflight_cnt + {1'b0, inflight_sr[i]};
    end
  end

  assign out_valid = (occ != 3'd0);
  assign pop       = out_valid & out_ready;
  // The word arriving during a flush cycle belongs to a discarded read.
  assign push      = inflight_sr[RD_LAT-1] & ~flush;

  // Slots already spoken for; the word leaving this cycle frees its slot.
  // pop implies occ >= 1, so this never underflows.
  assign credit_used = {1'b0, occ} + {2'b00, inflight_cnt} - {3'b000, pop};

  assign fifo_rdreq = run & ~fifo_empty & ~flush & (credit_used < 4'd4);

  assign rd_ptr_nxt = rd_ptr + {1'b0, pop};
  assign occ_nxt    = occ + {2'b00, push} - {2'b00, pop};

  // Next head word: if the skid is otherwise empty after this cycle's pop, the
  // word being pushed becomes the head; else it is already stored. Full+push
  // without pop cannot happen, so wr_ptr == rd_ptr_nxt only means "empty".
  assign head_nxt = (push && (wr_ptr == rd_ptr_nxt)) ? fifo_q : mem[rd_ptr_nxt];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run         <= 1'b0;
      occ         <= 3'd0;
      wr_ptr      <= 2'd0;
      rd_ptr      <= 2'd0;
      inflight_sr <= '0;
      word_cnt    <= 32'd0;
      flush_drop  <= 1'b0;
      out_data    <= '0;
    end else begin
      run        <= 1'b1;
      // A pop in the flush cycle is a real delivery and still counts.
      if (pop) word_cnt <= word_cnt + 32'd1;
      // At a flush, credit_used equals (occ - pop) + inflight: what is lost.
      flush_drop <= flush & (credit_used != 4'd0);
      if (flush) begin
        occ         <= 3'd0;
        wr_ptr      <= 2'd0;
        rd_ptr      <= 2'd0;
        inflight_sr <= '0;
      end else begin
        occ         <= occ_nxt;
        rd_ptr      <= rd_ptr_nxt;
        if (push) wr_ptr <= wr_ptr + 2'd1;
        // Shift in this cycle's request; the top bit marks fifo_q valid.
        inflight_sr <= RD_LAT'({inflight_sr, fifo_rdreq});
        // Hold out_data when the skid goes empty; it is don't-care then.
        if (occ_nxt != 3'd0) out_data <= head_nxt;
      end
    end
  end

  // NOTE: the skid storage has no reset; occ and the pointers define which
  // entries are meaningful, so clearing the data array would be wasted logic.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= fifo_q;
  end

  // Credit accounting must make a push into a full skid impossible.
  a_no_overrun: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (occ == 3'd4)));
  a_occ_range: assert property (@(posedge clk) disable iff (!rst_n)
    occ <= 3'd4);

endmodule

// File: tb/tb_fifo1c_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo1c_rd_stream
//
// Directed bench for fifo1c_rd_stream. Two instances run side by side:
// u0 with RD_LAT=1 and u1 with RD_LAT=2, each fed by a small upstream FIFO
// model with the matching read latency. Inputs change 1 time unit after the
// rising edge; a monitor on the falling edge checks every delivered word
// against the expected sequence.
// -----------------------------------------------------------------------------
module tb_fifo1c_rd_stream;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_empty [2];
  logic          fifo_rdreq [2];
  logic [DW-1:0] fifo_q     [2];
  logic          out_valid  [2];
  logic [DW-1:0] out_data   [2];
  logic          out_ready  [2];
  logic          flush      [2];
  logic [2:0]    occ        [2];
  logic [31:0]   word_cnt   [2];
  logic          flush_drop [2];

  // Upstream FIFO models
  logic [DW-1:0] fmem [2][64];
  int            head [2];
  int            tail [2];
  logic [DW-1:0] p1   [2];
  logic [DW-1:0] p2   [2];

  logic [DW-1:0] exp_next [2];
  logic          occ_chk;
  int            checks;
  int            errs;
  int            vcnt;
  int            runs;
  logic          prev_v;

  always #5 clk = ~clk;

  fifo1c_rd_stream #(.DW(DW), .RD_LAT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty[0]), .fifo_rdreq(fifo_rdreq[0]),
    .fifo_q(fifo_q[0]), .out_valid(out_valid[0]), .out_data(out_data[0]),
    .out_ready(out_ready[0]), .flush(flush[0]), .occ(occ[0]),
    .word_cnt(word_cnt[0]), .flush_drop(flush_drop[0])
  );

  fifo1c_rd_stream #(.DW(DW), .RD_LAT(2)) u1 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty[1]), .fifo_rdreq(fifo_rdreq[1]),
    .fifo_q(fifo_q[1]), .out_valid(out_valid[1]), .out_data(out_data[1]),
    .out_ready(out_ready[1]), .flush(flush[1]), .occ(occ[1]),
    .word_cnt(word_cnt[1]), .flush_drop(flush_drop[1])
  );

  assign fifo_empty[0] = (head[0] == tail[0]);
  assign fifo_empty[1] = (head[1] == tail[1]);
  assign fifo_q[0]     = p1[0];
  assign fifo_q[1]     = p2[1];

  // Upstream FIFO: data leaves the array on the edge that sees fifo_rdreq,
  // and appears one (p1) or two (p2) cycles later.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (fifo_rdreq[i]) begin
        p1[i]   <= fmem[i][head[i]];
        head[i] <= head[i] + 1;
      end else begin
        p1[i]   <= '1;
      end
      p2[i] <= p1[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Delivered-word scoreboard and per-cycle sanity checks.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          check($sformatf("data_u%0d", i), 64'(out_data[i]), 64'(exp_next[i]));
          exp_next[i] = exp_next[i] + 1'b1;
        end
        if (fifo_rdreq[i]) check($sformatf("rdreq_nonempty_u%0d", i), 64'(fifo_empty[i]), 64'd0);
        if (occ_chk) check($sformatf("occ_max_u%0d", i), 64'(occ[i] <= 3'd4), 64'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input int n, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++) fmem[i][tail[i] + k] = base + DW'(k);
    tail[i] = tail[i] + n;
  endtask

  task automatic wait_occ(input int i, input logic [2:0] v, input string tag);
    int n = 0;
    while (occ[i] !== v && n < 60) begin tick(); n++; end
    check(tag, 64'(occ[i]), 64'(v));
  endtask

  task automatic wait_cnt(input int i, input logic [31:0] v, input string tag);
    int n = 0;
    while (word_cnt[i] !== v && n < 200) begin tick(); n++; end
    check(tag, 64'(word_cnt[i]), 64'(v));
  endtask

  task automatic wait_valid(input int i, input string tag);
    int n = 0;
    while (out_valid[i] !== 1'b1 && n < 60) begin tick(); n++; end
    check(tag, 64'(out_valid[i]), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errs = 0; occ_chk = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      head[i] = 0; tail[i] = 0; p1[i] = '1; p2[i] = '1;
      out_ready[i] = 1'b0; flush[i] = 1'b0; exp_next[i] = '0;
    end

    // ---- Reset state, with u0's FIFO already holding 10 words --------------
    load(0, 10, 16'hA000);
    exp_next[0] = 16'hA000;
    out_ready[0] = 1'b1;
    tick(); tick(); tick();
    for (int i = 0; i < 2; i++) begin
      check("rst_occ",        64'(occ[i]),        64'd0);
      check("rst_out_valid",  64'(out_valid[i]),  64'd0);
      check("rst_out_data",   64'(out_data[i]),   64'd0);
      check("rst_word_cnt",   64'(word_cnt[i]),   64'd0);
      check("rst_flush_drop", 64'(flush_drop[i]), 64'd0);
      check("rst_rdreq",      64'(fifo_rdreq[i]), 64'd0);
    end

    // ---- RD_LAT=1 streaming, 10 words, out_ready high --------------------
    rst_n = 1'b1;
    #1;
    check("rdreq_before_first_edge", 64'(fifo_rdreq[0]), 64'd0);
    vcnt = 0; runs = 0; prev_v = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (c == 0) check("rdreq_after_first_edge", 64'(fifo_rdreq[0]), 64'd1);
      if (out_valid[0]) vcnt++;
      if (out_valid[0] && !prev_v) runs++;
      prev_v = out_valid[0];
    end
    check("lat1_valid_cycles", 64'(vcnt), 64'd10);
    check("lat1_valid_runs",   64'(runs), 64'd1);
    check("lat1_word_cnt",     64'(word_cnt[0]), 64'd10);
    check("lat1_rdreq_empty",  64'(fifo_rdreq[0]), 64'd0);

    // ---- RD_LAT=2, out_ready low, 8 words: skid fills to 4 ---------------
    load(1, 8, 16'hB000);
    exp_next[1] = 16'hB000;
    repeat (20) tick();
    check("lat2_pops_issued", 64'(head[1]), 64'd4);
    check("lat2_occ_full",    64'(occ[1]), 64'd4);
    check("lat2_rdreq_full",  64'(fifo_rdreq[1]), 64'd0);
    for (int c = 0; c < 3; c++) begin
      check("lat2_hold_data",  64'(out_data[1]), 64'hB000);
      check("lat2_hold_valid", 64'(out_valid[1]), 64'd1);
      tick();
    end
    out_ready[1] = 1'b1;
    wait_cnt(1, 32'd8, "lat2_word_cnt");
    check("lat2_drained_occ", 64'(occ[1]), 64'd0);

    // ---- Both latencies, out_ready toggling, 20 words each ---------------
    load(0, 20, 16'hC000);
    load(1, 20, 16'hD000);
    exp_next[0] = 16'hC000;
    exp_next[1] = 16'hD000;
    occ_chk = 1'b1;
    for (int c = 0; c < 150; c++) begin
      if (word_cnt[0] == 32'd30 && word_cnt[1] == 32'd28) break;
      out_ready[0] = c[0];
      out_ready[1] = c[0];
      tick();
    end
    occ_chk = 1'b0;
    out_ready[0] = 1'b0;
    out_ready[1] = 1'b0;
    check("toggle_word_cnt_u0", 64'(word_cnt[0]), 64'd30);
    check("toggle_word_cnt_u1", 64'(word_cnt[1]), 64'd28);

    // ---- Flush with occ=3 and one read in flight (RD_LAT=2) --------------
    load(1, 8, 16'hE000);
    wait_occ(1, 3'd3, "flush_setup_occ");
    check("flush_setup_rdreq", 64'(fifo_rdreq[1]), 64'd0);
    flush[1] = 1'b1;
    tick();
    flush[1] = 1'b0;
    check("flush_occ",       64'(occ[1]), 64'd0);
    check("flush_out_valid", 64'(out_valid[1]), 64'd0);
    check("flush_drop_hi",   64'(flush_drop[1]), 64'd1);
    check("flush_pops",      64'(head[1]), 64'd32);
    tick();
    check("flush_drop_lo",   64'(flush_drop[1]), 64'd0);
    check("flush_late_q",    64'(occ[1]), 64'd0);
    exp_next[1] = 16'hE004;
    out_ready[1] = 1'b1;
    wait_cnt(1, 32'd32, "flush_after_cnt");

    // ---- Flush in a cycle that also pops: pop counts, in-flight dropped ---
    exp_next[1] = 16'hF800;
    load(1, 2, 16'hF800);
    wait_valid(1, "popflush_setup");
    flush[1] = 1'b1;
    tick();
    flush[1] = 1'b0;
    check("popflush_word_cnt", 64'(word_cnt[1]), 64'd33);
    check("popflush_drop",     64'(flush_drop[1]), 64'd1);
    check("popflush_occ",      64'(occ[1]), 64'd0);
    tick();
    check("popflush_late_q",   64'(out_valid[1]), 64'd0);

    // ---- Reset mid-stream with occ=2 (RD_LAT=1) --------------------------
    out_ready[0] = 1'b0;
    load(0, 6, 16'hF000);
    wait_occ(0, 3'd2, "midrst_setup_occ");
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("midrst_occ",        64'(occ[i]), 64'd0);
      check("midrst_out_valid",  64'(out_valid[i]), 64'd0);
      check("midrst_out_data",   64'(out_data[i]), 64'd0);
      check("midrst_word_cnt",   64'(word_cnt[i]), 64'd0);
      check("midrst_flush_drop", 64'(flush_drop[i]), 64'd0);
      check("midrst_rdreq",      64'(fifo_rdreq[i]), 64'd0);
    end
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("midrst_pops_lost", 64'(head[0]), 64'd33);
    check("midrst_rel_rdreq", 64'(fifo_rdreq[0]), 64'd0);
    tick();
    check("midrst_rel_valid", 64'(out_valid[0]), 64'd0);
    exp_next[0] = 16'hF003;
    out_ready[0] = 1'b1;
    wait_cnt(0, 32'd3, "midrst_word_cnt");

    // ---- word_cnt wrap ---------------------------------------------------
    out_ready[0] = 1'b0;
    tick();
    force u0.word_cnt = 32'hFFFF_FFFE;
    #1;
    release u0.word_cnt;
    load(0, 3, 16'h9000);
    exp_next[0] = 16'h9000;
    out_ready[0] = 1'b1;
    wait_cnt(0, 32'h0000_0001, "wrap_word_cnt");
    repeat (3) tick();
    check("wrap_word_cnt_final", 64'(word_cnt[0]), 64'h1);
    check("wrap_occ_final",      64'(occ[0]), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
